square_wave_period_meter: RTL and testbench

SQUARE_WAVE_PERIOD_METER -- requirements
Module: square_wave_period_meter

---
 rtl/square_wave_period_meter_pkg.sv | 13 +
 rtl/square_wave_period_meter_edge_sync.sv | 34 +++
 rtl/square_wave_period_meter.sv | 121 ++++++++++++
 tb/tb_square_wave_period_meter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/square_wave_period_meter_pkg.sv
// Shared constants for the square-wave period meter: reset level, FSM encoding
// and the default measurement width.
package square_wave_period_meter_pkg;

    localparam logic RST_ACTIVE_LEVEL     = 1'b0;
    localparam int   DEFAULT_PERIOD_WIDTH = 32;

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        MEASURE    = 1'b1
    } state_t;

endpackage

// File: rtl/square_wave_period_meter_edge_sync.sv
// Input synchronizer plus one history flop; emits registered rise/fall strobes
// together with the synchronized level they describe.
module edge_sync
    import square_wave_period_meter_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;

    // sync is the history flop, so rise/fall in any cycle refer to the
    // transition into the level sync shows in that same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ACTIVE_LEVEL) begin
            chain <= '0;
            sync  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], in};
            sync  <= chain[STAGES-1];
            rise  <= chain[STAGES-1] & ~sync;
            fall  <= ~chain[STAGES-1] & sync;
        end
    end

endmodule

// File: rtl/square_wave_period_meter.sv
// Measures period and high time of an asynchronous square wave in clk cycles.
//   state      | meaning
//   WAIT_FIRST | idle or armed-pending: waiting for a rise to start counting
//   MEASURE    | counting cycles since the last rise
module square_wave_period_meter
    import square_wave_period_meter_pkg::*;
#(
    parameter int PERIOD_WIDTH = DEFAULT_PERIOD_WIDTH,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    in,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic [PERIOD_WIDTH-1:0] high_time,
    output logic                    valid,
    output logic                    timeout
);

    localparam logic [PERIOD_WIDTH-1:0] CNT_ONE  = PERIOD_WIDTH'(1);
    localparam logic [PERIOD_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [PERIOD_WIDTH-1:0] CNT_LAST = CNT_MAX - CNT_ONE;

    logic sync;
    logic rise;
    logic fall;

    edge_sync #(
        .STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .sync  (sync),
        .rise  (rise),
        .fall  (fall)
    );

    state_t                  state,         state_nxt;
    logic [PERIOD_WIDTH-1:0] cnt,           cnt_nxt;
    logic [PERIOD_WIDTH-1:0] hcnt,          hcnt_nxt;
    logic                    high_run,      high_run_nxt;
    logic [PERIOD_WIDTH-1:0] period_nxt,    high_time_nxt;
    logic                    valid_nxt,     timeout_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ACTIVE_LEVEL) begin
            state     <= WAIT_FIRST;
            cnt       <= '0;
            hcnt      <= '0;
            high_run  <= 1'b0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            hcnt      <= hcnt_nxt;
            high_run  <= high_run_nxt;
            period    <= period_nxt;
            high_time <= high_time_nxt;
            valid     <= valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        hcnt_nxt      = hcnt;
        high_run_nxt  = high_run;
        period_nxt    = period;
        high_time_nxt = high_time;
        valid_nxt     = 1'b0;
        timeout_nxt   = timeout;

        if (!enable) begin
            state_nxt   = WAIT_FIRST;
            timeout_nxt = 1'b0;
        end else begin
            case (state)
                WAIT_FIRST: begin
                    if (rise) begin
                        state_nxt    = MEASURE;
                        cnt_nxt      = CNT_ONE;
                        hcnt_nxt     = CNT_ONE;
                        high_run_nxt = 1'b1;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_nxt    = cnt;
                        high_time_nxt = hcnt;
                        valid_nxt     = 1'b1;
                        timeout_nxt   = 1'b0;
                        cnt_nxt       = CNT_ONE;
                        hcnt_nxt      = CNT_ONE;
                        high_run_nxt  = 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        // Saturate at all-ones rather than wrap; a rise in this
                        // same cycle is handled by the branch above.
                        cnt_nxt     = CNT_MAX;
                        timeout_nxt = 1'b1;
                        state_nxt   = WAIT_FIRST;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                        if (fall) begin
                            high_run_nxt = 1'b0;
                        end else if (high_run && sync) begin
                            hcnt_nxt = hcnt + CNT_ONE;
                        end
                    end
                end
                default: state_nxt = WAIT_FIRST;
            endcase
        end
    end

endmodule

// File: tb/tb_square_wave_period_meter.sv
// Scoreboard bench for square_wave_period_meter: a sample-history reference model
// predicts measurements and timeout; a negedge monitor compares DUT outputs.
`timescale 1ns/1ps
module tb_square_wave_period_meter;

    localparam int PW       = 8;
    localparam int SS       = 2;
    localparam int DET      = SS + 1;           // edges from first high sample to the FSM acting on it
    localparam int TO_LIMIT = (1 << PW) - 2;    // cycles after arming at which timeout rises

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          enable = 1'b0;
    logic          in     = 1'b0;
    logic [PW-1:0] period;
    logic [PW-1:0] high_time;
    logic          valid;
    logic          timeout;

    square_wave_period_meter #(
        .PERIOD_WIDTH (PW),
        .SYNC_STAGES  (SS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .in        (in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int p;
        int h;
    } meas_t;

    meas_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: keeps every sampled input value; a rise of the sampled
    // input takes effect DET edges later; period/high come from the history.
    int samp[$];
    bit armed       = 1'b0;
    int last_j      = 0;
    bit exp_timeout = 1'b0;

    always @(posedge clk) begin
        int j;
        int hsum;
        bit r;
        meas_t m;
        samp.push_back((rst_n && in) ? 1 : 0);
        if (!rst_n) begin
            armed       = 1'b0;
            exp_timeout = 1'b0;
        end else begin
            j = samp.size() - 1 - DET;
            r = (j >= 1) && (samp[j] == 1) && (samp[j-1] == 0);
            if (!enable) begin
                armed       = 1'b0;
                exp_timeout = 1'b0;
            end else if (r) begin
                if (armed) begin
                    hsum = 0;
                    for (int k = last_j; k < j; k++) hsum += samp[k];
                    m.p = j - last_j;
                    m.h = hsum;
                    exp_q.push_back(m);
                    exp_timeout = 1'b0;
                end
                armed  = 1'b1;
                last_j = j;
            end else if (armed && (j - last_j == TO_LIMIT)) begin
                exp_timeout = 1'b1;
                armed       = 1'b0;
            end
        end
    end

    // Monitor
    int hold_p = 0;
    int hold_h = 0;

    always @(negedge clk) begin
        meas_t m;
        if (!rst_n) begin
            hold_p = 0;
            hold_h = 0;
        end
        check("valid", int'(valid), exp_q.size());
        if (valid && exp_q.size() > 0) begin
            m      = exp_q.pop_front();
            hold_p = m.p;
            hold_h = m.h;
        end
        check("period", int'(period), hold_p);
        check("high_time", int'(high_time), hold_h);
        check("timeout", int'(timeout), int'(exp_timeout));
    end

    task automatic wave(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            in = 1'b1;
            repeat (h) @(negedge clk);
            in = 1'b0;
            repeat (l) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        #1 rst_n = 1'b0;
        #1;
        check("rst_period", int'(period), 0);
        check("rst_high_time", int'(high_time), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_timeout", int'(timeout), 0);
        repeat (n) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int  lat;
        bit  found;
        rst_n  = 1'b0;
        enable = 1'b0;
        in     = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        rst_n  = 1'b1;
        enable = 1'b1;
        @(negedge clk);

        // steady 5/5 wave
        wave(5, 5, 6);
        // duty change at constant period
        wave(1, 3, 4);
        wave(3, 1, 4);
        idle(5);

        // arm with a single rise, then hold low through timeout
        in = 1'b1;
        repeat (3) @(negedge clk);
        idle(TO_LIMIT + 16);
        wave(4, 4, 3);

        // reset in the middle of a 10-cycle wave
        fork
            wave(5, 5, 5);
            begin
                repeat (23) @(negedge clk);
                do_reset(6);
            end
        join
        @(negedge clk);

        // enable dropped for 3 cycles during an 8-cycle wave
        fork
            wave(4, 4, 8);
            begin
                repeat (21) @(negedge clk);
                enable = 1'b0;
                repeat (3) @(negedge clk);
                enable = 1'b1;
            end
        join

        // isolated rise, then latency of the next rise
        idle(10);
        in = 1'b1;
        repeat (2) @(negedge clk);
        idle(30);
        in    = 1'b1;
        lat   = 0;
        found = 1'b0;
        for (int k = 1; k <= 20 && !found; k++) begin
            @(negedge clk);
            if (valid) begin
                found = 1'b1;
                lat   = k;
            end
        end
        check("latency", lat, SS + 2);
        idle(4);
        wave(2, 3, 3);

        // randomized traffic
        for (int it = 0; it < 50; it++) begin
            int sel;
            int h;
            int l;
            int n;
            sel = $urandom_range(0, 99);
            h   = $urandom_range(1, 12);
            l   = $urandom_range(1, 12);
            n   = $urandom_range(2, 5);
            if (sel < 70) begin
                wave(h, l, n);
            end else if (sel < 85) begin
                fork
                    wave(h, l, n);
                    begin
                        repeat ($urandom_range(1, (h + l) * n - 1)) @(negedge clk);
                        enable = 1'b0;
                        repeat ($urandom_range(1, 4)) @(negedge clk);
                        enable = 1'b1;
                    end
                join
            end else if (sel < 95) begin
                fork
                    wave(h, l, n);
                    begin
                        repeat ($urandom_range(1, (h + l) * n - 1)) @(negedge clk);
                        do_reset(6);
                    end
                join
                @(negedge clk);
            end else begin
                in = 1'b1;
                repeat (h) @(negedge clk);
                idle(TO_LIMIT + 10);
            end
        end

        idle(DET + 4);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
